// File: rtl/vproc_mem_resp_pipe_if.sv
// Core-side memory port of vproc_mem_resp_pipe: request fields driven by the
// core, response fields returned by the adapter. There is no grant and no
// backpressure, so every request is accepted in the cycle it is presented.
interface vproc_mem_resp_pipe_if;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;

    // Core side: issues requests, consumes responses.
    modport master (
        output req, addr, we, be, wdata,
        input  rvalid, err, rdata
    );

    // Adapter side: consumes requests, produces responses.
    modport slave (
        input  req, addr, we, be, wdata,
        output rvalid, err, rdata
    );
endinterface

// File: rtl/vproc_mem_resp_pipe.sv
// vproc_mem_resp_pipe
// Adapter between the vproc core memory port and a single-port synchronous
// SRAM with one cycle of read latency. Requests pass straight through to the
// SRAM when in range; responses are stretched to a fixed MEM_LATENCY, with
// out-of-range accesses flagged and never touching the SRAM. A request to
// END_ADDR marks program completion and freezes the free-running cycle counter.
module vproc_mem_resp_pipe #(
    parameter int          MEM_SZ      = 262144,
    parameter int          MEM_LATENCY = 1,
    parameter logic [31:0] END_ADDR    = 32'h0,
    parameter int          CNT_W       = 32,
    localparam int         AB          = $clog2(MEM_SZ),
    localparam int         AW          = AB - 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    vproc_mem_resp_pipe_if.slave  mem,
    output logic                  sram_req_o,
    output logic [AW-1:0]         sram_addr_o,
    output logic                  sram_we_o,
    output logic [3:0]            sram_be_o,
    output logic [31:0]           sram_wdata_o,
    input  logic [31:0]           sram_rdata_i,
    output logic                  prog_end_o,
    output logic                  done_o,
    output logic [CNT_W-1:0]      cycle_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // An address is in range when no bit at or above the memory size is set.
    function automatic logic addr_in_range(input logic [31:0] a);
        return (a >> AB) == 32'd0;
    endfunction

    logic              in_range;
    logic              req_act;

    logic              vld_p1;
    logic              err_p1;
    logic              rdsel_p1;
    logic [31:0]       data_p1;

    logic              vld_out;
    logic              err_out;
    logic [31:0]       data_out;

    logic              done_q;
    logic [CNT_W-1:0]  cnt_q;

    // Every output is forced low while reset is asserted, including the
    // combinational SRAM pass-through, so nothing reaches the SRAM in reset.
    assign req_act      = rst_ni & mem.req;
    assign in_range     = addr_in_range(mem.addr);

    assign sram_req_o   = req_act & in_range;
    assign sram_addr_o  = rst_ni ? mem.addr[AB-1:2] : '0;
    assign sram_we_o    = rst_ni & mem.we;
    assign sram_be_o    = rst_ni ? mem.be : 4'h0;
    assign sram_wdata_o = rst_ni ? mem.wdata : 32'h0;

    // Only the first END_ADDR request after reset produces the pulse.
    assign prog_end_o   = req_act & (mem.addr == END_ADDR) & ~done_q;
    assign done_o       = done_q;
    assign cycle_cnt_o  = cnt_q;

    // Stage 1: capture request attributes at the edge the SRAM is accessed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
            rdsel_p1 <= 1'b0;
        end else begin
            vld_p1   <= mem.req;
            err_p1   <= mem.req & ~in_range;
            rdsel_p1 <= mem.req & in_range & ~mem.we;
        end
    end

    // SRAM read data is only valid during stage 1, so stage-1 data is taken
    // from it directly; writes and errors return zero.
    assign data_p1 = rdsel_p1 ? sram_rdata_i : 32'h0;

    // ---- stage 1 -> stages 2..MEM_LATENCY ----
    generate
        if (MEM_LATENCY == 1) begin : g_lat1
            assign vld_out  = vld_p1;
            assign err_out  = err_p1;
            assign data_out = data_p1;
        end else begin : g_latn
            logic        vld_pn  [2:MEM_LATENCY];
            logic        err_pn  [2:MEM_LATENCY];
            logic [31:0] data_pn [2:MEM_LATENCY];

            // Delay line for valid/error; cleared so in-flight responses die on reset.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int s = 2; s <= MEM_LATENCY; s++) begin
                        vld_pn[s] <= 1'b0;
                        err_pn[s] <= 1'b0;
                    end
                end else begin
                    vld_pn[2] <= vld_p1;
                    err_pn[2] <= err_p1;
                    for (int s = 3; s <= MEM_LATENCY; s++) begin
                        vld_pn[s] <= vld_pn[s-1];
                        err_pn[s] <= err_pn[s-1];
                    end
                end
            end

            // Delay line for data; qualified by valid at the output, so no reset.
            always_ff @(posedge clk_i) begin
                data_pn[2] <= data_p1;
                for (int s = 3; s <= MEM_LATENCY; s++) begin
                    data_pn[s] <= data_pn[s-1];
                end
            end

            assign vld_out  = vld_pn[MEM_LATENCY];
            assign err_out  = err_pn[MEM_LATENCY];
            assign data_out = data_pn[MEM_LATENCY];
        end
    endgenerate

    // ---- response output ----
    assign mem.rvalid = vld_out;
    assign mem.err    = err_out;
    assign mem.rdata  = vld_out ? data_out : 32'h0;

    // Cycle counter runs until the end request; the counter still advances at
    // the edge that sets done, so it includes the end request's cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (prog_end_o) begin
                done_q <= 1'b1;
            end
            if (!done_q) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_vproc_mem_resp_pipe.sv
// Testbench for vproc_mem_resp_pipe. Three instances (latency 1, 3 and 4) see
// identical stimulus, each behind its own SRAM model. Issued requests are
// pushed as expected transactions; a per-instance monitor consumes them when
// the instance presents rvalid.
`timescale 1ns/1ps
module tb_vproc_mem_resp_pipe;
    localparam int          MEM_SZ   = 262144;
    localparam int          NWORDS   = MEM_SZ / 4;
    localparam logic [31:0] END_ADDR = 32'h0000_2000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        req   = 1'b0;
    logic [31:0] addr  = 32'h0;
    logic        we    = 1'b0;
    logic [3:0]  be    = 4'h0;
    logic [31:0] wdata = 32'h0;

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;

    typedef struct {
        int          edge_n;
        logic        err;
        logic [31:0] rdata;
    } txn_t;

    txn_t        txq[$];
    logic [31:0] ref_mem [NWORDS];
    logic [31:0] m_cnt  = 32'h0;
    logic        m_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) edge_cnt++;

    // Program-completion model: counts edges since reset release until the first end request.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  = 32'h0;
            m_done = 1'b0;
        end else begin
            if (!m_done) m_cnt = m_cnt + 32'd1;
            if (req && addr == END_ADDR) m_done = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int L = (gi == 0) ? 1 : ((gi == 1) ? 3 : 4);

            vproc_mem_resp_pipe_if bus ();
            logic        sram_req, sram_we, prog_end, done;
            logic [15:0] sram_addr;
            logic [3:0]  sram_be;
            logic [31:0] sram_wdata, cnt;
            logic [31:0] sram_rdata = 32'h0;
            logic [31:0] sram [NWORDS];
            int          rd_idx = 0;

            assign bus.req   = req;
            assign bus.addr  = addr;
            assign bus.we    = we;
            assign bus.be    = be;
            assign bus.wdata = wdata;

            vproc_mem_resp_pipe #(
                .MEM_SZ(MEM_SZ), .MEM_LATENCY(L), .END_ADDR(END_ADDR), .CNT_W(32)
            ) dut (
                .clk_i(clk), .rst_ni(rst_n), .mem(bus),
                .sram_req_o(sram_req), .sram_addr_o(sram_addr), .sram_we_o(sram_we),
                .sram_be_o(sram_be), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata),
                .prog_end_o(prog_end), .done_o(done), .cycle_cnt_o(cnt)
            );

            initial for (int i = 0; i < NWORDS; i++) sram[i] = 32'h0;

            // Single-port SRAM, one cycle read latency.
            always @(posedge clk) begin
                if (sram_req) begin
                    if (sram_we) begin
                        for (int b = 0; b < 4; b++)
                            if (sram_be[b]) sram[sram_addr][8*b +: 8] = sram_wdata[8*b +: 8];
                    end else begin
                        sram_rdata <= sram[sram_addr];
                    end
                end
            end

            // Monitor: response scoreboard plus pass-through and counter checks.
            always @(negedge clk) begin
                if (!rst_n) begin
                    rd_idx = txq.size();
                    chk($sformatf("L%0d_reset_outputs_zero", L),
                        64'(|{bus.rvalid, bus.err, bus.rdata, sram_req, sram_addr, sram_we,
                              sram_be, sram_wdata, prog_end, done, cnt}), 64'd0);
                end else begin
                    while (rd_idx < txq.size() && txq[rd_idx].edge_n + L - 1 < edge_cnt) begin
                        checks++;
                        errors++;
                        $display("FAIL L%0d_missing_rvalid txn %0d actual=none required=rvalid after edge %0d",
                                 L, rd_idx, txq[rd_idx].edge_n + L - 1);
                        rd_idx++;
                    end
                    if (bus.rvalid) begin
                        if (rd_idx >= txq.size()) begin
                            checks++;
                            errors++;
                            $display("FAIL L%0d_unexpected_rvalid actual=1 required=0 at edge %0d", L, edge_cnt);
                        end else begin
                            chk($sformatf("L%0d_latency_txn%0d", L, rd_idx), 64'(edge_cnt),
                                64'(txq[rd_idx].edge_n + L - 1));
                            chk($sformatf("L%0d_err_txn%0d", L, rd_idx), 64'(bus.err), 64'(txq[rd_idx].err));
                            chk($sformatf("L%0d_rdata_txn%0d", L, rd_idx), 64'(bus.rdata), 64'(txq[rd_idx].rdata));
                            rd_idx++;
                        end
                    end
                    chk($sformatf("L%0d_sram_req", L), 64'(sram_req), 64'(req && (addr < 32'(MEM_SZ))));
                    chk($sformatf("L%0d_prog_end", L), 64'(prog_end),
                        64'(req && addr == END_ADDR && !m_done));
                    chk($sformatf("L%0d_done", L), 64'(done), 64'(m_done));
                    chk($sformatf("L%0d_cycle_cnt", L), 64'(cnt), 64'(m_cnt));
                end
            end
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Set the inputs sampled at the next edge and record the expected response.
    task automatic drive(input logic r, input logic [31:0] a, input logic w,
                         input logic [3:0] bb, input logic [31:0] d);
        txn_t t;
        int   widx;
        req = r; addr = a; we = w; be = bb; wdata = d;
        if (r && rst_n) begin
            widx     = int'((a >> 2) & 32'(NWORDS - 1));
            t.edge_n = edge_cnt + 1;
            t.err    = (a >= 32'(MEM_SZ));
            if (!t.err && w) begin
                for (int b = 0; b < 4; b++)
                    if (bb[b]) ref_mem[widx][8*b +: 8] = d[8*b +: 8];
            end
            t.rdata = (!t.err && !w) ? ref_mem[widx] : 32'h0;
            txq.push_back(t);
        end
    endtask

    task automatic op(input logic r, input logic [31:0] a, input logic w,
                      input logic [3:0] bb, input logic [31:0] d);
        tick();
        drive(r, a, w, bb, d);
    endtask

    task automatic idle();
        op(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic rand_op();
        logic        r, w;
        logic [31:0] a;
        r = ($urandom_range(0, 3) != 0);
        w = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 7) == 0)
            a = (32'($urandom_range(1, 16383)) << 18) | 32'($urandom_range(0, 262143));
        else
            a = 32'($urandom_range(0, 255));
        op(r, a, w, 4'($urandom_range(0, 15)), $urandom());
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        drive(1'b1, $urandom(), 1'b0, 4'hF, $urandom());
        repeat (3) begin
            tick();
            drive(1'b1, $urandom(), 1'b0, 4'hF, $urandom());
        end
        tick();
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NWORDS; i++) ref_mem[i] = 32'h0;
        #2 rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);

        // Preload and read back one word.
        op(1'b1, 32'h100, 1'b1, 4'hF, 32'hDEAD_BEEF);
        op(1'b1, 32'h100, 1'b0, 4'h0, 32'h0);
        idle();
        chk("t1_rvalid", 64'(g_dut[0].bus.rvalid), 64'd1);
        chk("t1_rdata", 64'(g_dut[0].bus.rdata), 64'hDEAD_BEEF);
        chk("t1_err", 64'(g_dut[0].bus.err), 64'd0);

        // Byte-enable merge over an all-ones word.
        op(1'b1, 32'h20, 1'b1, 4'hF, 32'hFFFF_FFFF);
        op(1'b1, 32'h20, 1'b1, 4'b0101, 32'h1234_5678);
        op(1'b1, 32'h20, 1'b0, 4'h0, 32'h0);
        idle();
        chk("t3_merged_rdata", 64'(g_dut[0].bus.rdata), 64'hFF34_FF78);

        // Back-to-back reads of three words.
        op(1'b1, 32'h10, 1'b1, 4'hF, 32'hA0A0_0010);
        op(1'b1, 32'h14, 1'b1, 4'hF, 32'hB0B0_0014);
        op(1'b1, 32'h18, 1'b1, 4'hF, 32'hC0C0_0018);
        op(1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
        op(1'b1, 32'h14, 1'b0, 4'h0, 32'h0);
        op(1'b1, 32'h18, 1'b0, 4'h0, 32'h0);
        repeat (5) idle();

        // Out-of-range read and write never reach the SRAM.
        op(1'b1, 32'h0, 1'b1, 4'hF, 32'hCAFE_F00D);
        op(1'b1, 32'h0004_0000, 1'b0, 4'h0, 32'h0);
        #1 chk("t4_sram_req_blocked", 64'(g_dut[0].sram_req), 64'd0);
        op(1'b1, 32'h0004_0000, 1'b1, 4'hF, 32'h1111_1111);
        op(1'b1, 32'h0, 1'b0, 4'h0, 32'h0);
        repeat (5) idle();

        // Random traffic, including read-after-write to the same word.
        repeat (300) rand_op();
        repeat (5) idle();

        // Reset while a read is in flight.
        op(1'b1, 32'h100, 1'b0, 4'h0, 32'h0);
        idle();
        tick();
        tick();
        rst_n = 1'b0;
        drive(1'b1, $urandom(), 1'b0, 4'hF, $urandom());
        repeat (3) begin
            tick();
            drive(1'b1, $urandom(), 1'b0, 4'hF, $urandom());
        end
        tick();
        rst_n = 1'b1;
        drive(1'b1, 32'h100, 1'b0, 4'h0, 32'h0);
        #1 chk("t6_cnt_restart", 64'(g_dut[2].cnt), 64'd0);
        repeat (6) idle();

        // End-of-program fetch on the 50th edge after reset release.
        do_reset();
        repeat (48) begin
            rand_op();
        end
        op(1'b1, END_ADDR, 1'b0, 4'h0, 32'h0);
        #1 chk("t5_prog_end_pulse", 64'(g_dut[0].prog_end), 64'd1);
        idle();
        chk("t5_done_set", 64'(g_dut[0].done), 64'd1);
        chk("t5_cnt_frozen", 64'(g_dut[0].cnt), 64'd50);
        op(1'b1, END_ADDR, 1'b0, 4'h0, 32'h0);
        #1 chk("t5_no_second_pulse", 64'(g_dut[0].prog_end), 64'd0);
        repeat (10) idle();
        chk("t5_cnt_still_frozen", 64'(g_dut[1].cnt), 64'd50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
